// File: rtl/mips150_io_ctrl.sv
// Memory-mapped IO slave for MIPS150: UART RX/TX FIFOs, status, and optional counters.
// Define MIPS150_IO_COUNTERS_EN to build the cycle/instruction counters and their clear register.
module mips150_io_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [3:0]  io_we,
    input  logic [31:0] io_wdata,
    input  logic        io_re,
    input  logic        instr_retire,
    output logic [31:0] io_rdata,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    localparam logic [2:0] SEL_STATUS = 3'd0;
    localparam logic [2:0] SEL_RX     = 3'd1;
    localparam logic [2:0] SEL_TX     = 3'd2;
    localparam logic [2:0] SEL_CYC    = 3'd4;
    localparam logic [2:0] SEL_INSTR  = 3'd5;
    localparam logic [2:0] SEL_CLR    = 3'd6;

    localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    logic [2:0] sel;
    logic       wr_any;

    assign sel    = io_addr[4:2];
    assign wr_any = |io_we;

    logic [7:0]         rx_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [FIFO_AW:0]   rx_count;
    logic               rx_full, rx_empty, rx_push, rx_pop;

    logic [7:0]         tx_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [FIFO_AW:0]   tx_count;
    logic               tx_full, tx_empty, tx_push, tx_pop;

    assign rx_full  = (rx_count == DEPTH_CNT);
    assign rx_empty = (rx_count == '0);
    assign tx_full  = (tx_count == DEPTH_CNT);
    assign tx_empty = (tx_count == '0);

    // Full/empty come from registered counts only, so a same-cycle pop never opens room for a push.
    assign rx_push = uart_rx_valid && !rx_full;
    assign rx_pop  = io_re && (sel == SEL_RX) && !rx_empty;
    assign tx_push = wr_any && (sel == SEL_TX) && !tx_full;
    assign tx_pop  = uart_tx_ready && !tx_empty;

    assign uart_rx_ready = !rx_full;
    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= io_wdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_ONE;
                2'b01:   rx_count <= rx_count - CNT_ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_ONE;
                2'b01:   tx_count <= tx_count - CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

`ifdef MIPS150_IO_COUNTERS_EN
    logic [31:0] cyc_cnt, instr_cnt;
    logic        cnt_clr;

    assign cnt_clr = wr_any && (sel == SEL_CLR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (instr_retire) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

    logic [31:0] rd_next;

    always_comb begin
        rd_next = '0;
        case (sel)
            SEL_STATUS: rd_next = {30'b0, !rx_empty, !tx_full};
            SEL_RX:     if (!rx_empty) rd_next = {24'b0, rx_mem[rx_rd_ptr]};
`ifdef MIPS150_IO_COUNTERS_EN
            SEL_CYC:    rd_next = cyc_cnt;
            SEL_INSTR:  rd_next = instr_cnt;
`endif
            default:    rd_next = '0;
        endcase
    end

    // Load data lands in M stage and holds until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        io_rdata <= '0;
        else if (io_re) io_rdata <= rd_next;
    end

    logic unused_bits;
`ifdef MIPS150_IO_COUNTERS_EN
    assign unused_bits = ^{io_addr[31:5], io_addr[1:0], io_wdata[31:8]};
`else
    assign unused_bits = ^{io_addr[31:5], io_addr[1:0], io_wdata[31:8], instr_retire, SEL_CYC, SEL_INSTR, SEL_CLR};
`endif

endmodule

// File: tb/tb_mips150_io_ctrl.sv
// Bench for mips150_io_ctrl: queue-based reference model checked every cycle plus directed literal checks.
module tb_mips150_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_addr;
    logic [3:0]  io_we;
    logic [31:0] io_wdata;
    logic        io_re;
    logic        instr_retire;
    logic [31:0] io_rdata;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    int checks   = 0;
    int failures = 0;

    mips150_io_ctrl #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk(clk), .rst(rst),
        .io_addr(io_addr), .io_we(io_we), .io_wdata(io_wdata), .io_re(io_re),
        .instr_retire(instr_retire), .io_rdata(io_rdata),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: FIFOs as queues, counters as plain integers.
    logic [7:0]  m_rxq[$];
    logic [7:0]  m_txq[$];
    logic [31:0] m_rdata;
    logic [31:0] m_cyc, m_instr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rxq.delete();
            m_txq.delete();
            m_rdata = 32'h0;
            m_cyc   = 32'h0;
            m_instr = 32'h0;
        end else begin
            logic [4:0] off;
            logic       rx_acc, tx_acc, tx_pop, clr;
            off    = {io_addr[4:2], 2'b00};
            rx_acc = uart_rx_valid && (m_rxq.size() < 8);
            tx_acc = (io_we != 4'h0) && (off == 5'h08) && (m_txq.size() < 8);
            tx_pop = uart_tx_ready && (m_txq.size() > 0);
            clr    = (io_we != 4'h0) && (off == 5'h18);
            if (io_re) begin
                case (off)
                    5'h00: m_rdata = {30'h0, m_rxq.size() != 0, m_txq.size() != 8};
                    5'h04: m_rdata = (m_rxq.size() != 0) ? {24'h0, m_rxq[0]} : 32'h0;
`ifdef MIPS150_IO_COUNTERS_EN
                    5'h10: m_rdata = m_cyc;
                    5'h14: m_rdata = m_instr;
`endif
                    default: m_rdata = 32'h0;
                endcase
                if (off == 5'h04 && m_rxq.size() != 0) void'(m_rxq.pop_front());
            end
            if (rx_acc) m_rxq.push_back(uart_rx_data);
            if (tx_pop) void'(m_txq.pop_front());
            if (tx_acc) m_txq.push_back(io_wdata[7:0]);
            if (clr) begin
                m_cyc   = 32'h0;
                m_instr = 32'h0;
            end else begin
                m_cyc = m_cyc + 32'd1;
                if (instr_retire) m_instr = m_instr + 32'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_tx_valid", {31'h0, uart_tx_valid}, {31'h0, m_txq.size() != 0});
            chk("cyc_tx_data", {24'h0, uart_tx_data}, (m_txq.size() != 0) ? {24'h0, m_txq[0]} : 32'h0);
            chk("cyc_rx_ready", {31'h0, uart_rx_ready}, {31'h0, m_rxq.size() < 8});
            chk("cyc_rdata", io_rdata, m_rdata);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        io_addr = addr;
        io_re   = 1'b1;
        tick(1);
        io_re   = 1'b0;
        data    = io_rdata;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        io_addr  = addr;
        io_wdata = data;
        io_we    = 4'hF;
        tick(1);
        io_we    = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        rst = 1'b1; io_addr = 32'h8000_0000; io_we = 4'h0; io_wdata = 32'h0; io_re = 1'b0;
        instr_retire = 1'b0; uart_rx_data = 8'h0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        chk("reset_rdata", io_rdata, 32'h0);
        rd(32'h8000_0000, d);
        chk("reset_status", d, 32'h0000_0001);
        chk("reset_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("reset_rx_ready", {31'h0, uart_rx_ready}, 32'h1);

        // TX fill with overflow, then drain
        for (int i = 0; i < 9; i++) wr(32'h8000_0008, 32'hFFFF_FF41 + i);
        rd(32'h8000_0000, d);
        chk("tx_full_status", d, 32'h0);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("tx_drain_data", {24'h0, uart_tx_data}, 32'h41 + i);
            tick(1);
        end
        chk("tx_drained_valid", {31'h0, uart_tx_valid}, 32'h0);
        uart_tx_ready = 1'b0;

        // RX path
        uart_rx_valid = 1'b1; uart_rx_data = 8'h5A; tick(1);
        uart_rx_data = 8'hA5; tick(1);
        uart_rx_valid = 1'b0;
        rd(32'h8000_0000, d); chk("rx_status_before", d, 32'h3);
        rd(32'h8000_0004, d); chk("rx_read0", d, 32'h5A);
        rd(32'h8000_0004, d); chk("rx_read1", d, 32'hA5);
        rd(32'h8000_0004, d); chk("rx_read_empty", d, 32'h0);
        rd(32'h8000_0000, d); chk("rx_status_after", d, 32'h1);

        // RX full with a simultaneous pop
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            uart_rx_data = 8'h10 + 8'(i);
            tick(1);
        end
        chk("rx_full_ready", {31'h0, uart_rx_ready}, 32'h0);
        uart_rx_data = 8'hEE;
        rd(32'h8000_0004, d);
        uart_rx_valid = 1'b0;
        chk("rx_full_pop", d, 32'h10);
        rd(32'h8000_0000, d); chk("rx_after_pop_status", d, 32'h3);
        for (int i = 1; i < 8; i++) begin
            rd(32'h8000_0004, d);
            chk("rx_remaining", d, 32'h10 + i);
        end
        rd(32'h8000_0004, d); chk("rx_no_ee", d, 32'h0);

        // Writes to read-only/unmapped offsets are ignored; unmapped reads are 0
        wr(32'h8000_0000, 32'h55);
        wr(32'h8000_000C, 32'h66);
        rd(32'h8000_000C, d); chk("unmapped_0c", d, 32'h0);
        rd(32'h8000_001C, d); chk("unmapped_1c", d, 32'h0);
        rd(32'h8000_0000, d); chk("status_unchanged", d, 32'h1);

        // Counters
        wr(32'h8000_0018, 32'h1);
        for (int i = 0; i < 100; i++) begin
            instr_retire = (i % 2 == 0) && (i < 74);
            tick(1);
        end
        instr_retire = 1'b0;
        rd(32'h8000_0010, d);
`ifdef MIPS150_IO_COUNTERS_EN
        chk("cycle_count", d, 32'd100);
`else
        chk("cycle_count_off", d, 32'h0);
`endif
        rd(32'h8000_0014, d);
`ifdef MIPS150_IO_COUNTERS_EN
        chk("instr_count", d, 32'd37);
`else
        chk("instr_count_off", d, 32'h0);
`endif

        // Asynchronous reset mid-traffic
        for (int i = 0; i < 3; i++) wr(32'h8000_0008, 32'h70 + i);
        chk("tx_holding", {31'h0, uart_tx_valid}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("async_rdata", io_rdata, 32'h0);
        chk("async_tx_data", {24'h0, uart_tx_data}, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick(1);
        rd(32'h8000_0000, d); chk("post_reset_status", d, 32'h1);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
